audio_adc_rx: RTL and testbench

Receive-side counterpart of the audio DAC serializer. Deserializes the codec's left-justified ADC stream (ADCDAT, framed by ADCLRCK, bit-clocked by BCLK) into 16-bit stereo sample pairs in the CLOCK domain. Presents each pair through a valid/ready handshake and flags overrun and short-word errors. Includes a peak-level detector with a threshold and hold, for sound-triggered features such as alarm stop.

---
 rtl/audio_adc_rx.sv | 208 ++++++++++++++++++++
 tb/tb_audio_adc_rx.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_adc_rx.sv
// audio_adc_rx
// Receives the codec's left-justified ADC stream and turns it into 16-bit
// stereo pairs in the CLOCK domain, with a level detector for sound-triggered
// features.
//
// Ports:
//   CLOCK         system clock, all registers on its rising edge
//   DLY_RST       asynchronous active-low reset
//   BCLK          codec bit clock (asynchronous, at most CLOCK/8)
//   ADCLRCK       frame clock, 1 = left slot, 0 = right slot
//   ADCDAT        serial data, MSB first, valid at BCLK rising edge
//   SAMPLE_READY  consumer takes the pair when high with SAMPLE_VALID
//   CLR_ERR       clears OVERRUN and SHORT_ERR (a same-cycle set wins)
//   SAMPLE_L/R    held stereo pair, two's complement
//   SAMPLE_VALID  pair held and not yet accepted
//   OVERRUN       sticky, a completed pair was dropped
//   SHORT_ERR     sticky, a slot ended before DATA_WIDTH bits
//   LEVEL         max(|L|,|R|) of the last completed pair
//   SOUND_DET     level over THRESHOLD, held for HOLD_PAIRS pairs
module audio_adc_rx #(
    parameter int                    DATA_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] THRESHOLD  = 16'd8000,
    parameter int                    HOLD_PAIRS = 4800
) (
    input  logic                  CLOCK,
    input  logic                  DLY_RST,
    input  logic                  BCLK,
    input  logic                  ADCLRCK,
    input  logic                  ADCDAT,
    input  logic                  SAMPLE_READY,
    input  logic                  CLR_ERR,
    output logic [DATA_WIDTH-1:0] SAMPLE_L,
    output logic [DATA_WIDTH-1:0] SAMPLE_R,
    output logic                  SAMPLE_VALID,
    output logic                  OVERRUN,
    output logic                  SHORT_ERR,
    output logic [DATA_WIDTH-1:0] LEVEL,
    output logic                  SOUND_DET
);

    localparam int                 CNT_W     = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0]   CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0]   CNT_FULL  = CNT_W'(DATA_WIDTH);
    localparam logic [12:0]        HOLD_LOAD = 13'(HOLD_PAIRS);

    // Magnitude of a two's complement word; the most negative value saturates.
    function automatic logic [DATA_WIDTH-1:0] abs_sat(input logic [DATA_WIDTH-1:0] x);
        logic [DATA_WIDTH-1:0] most_neg;
        logic [DATA_WIDTH-1:0] res;
        most_neg = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        if (x == most_neg) begin
            res = ~most_neg;
        end else if (x[DATA_WIDTH-1]) begin
            res = ~x + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            res = x;
        end
        return res;
    endfunction

    logic                  bclk_meta_r, bclk_sync_r, bclk_dly_r;
    logic                  lrck_meta_r, lrck_sync_r;
    logic                  dat_meta_r, dat_sync_r;
    logic                  bclk_rise_s;

    logic                  lrck_prev_r;
    logic                  prev_vld_r;
    logic [CNT_W-1:0]      bitcnt_r;
    logic [DATA_WIDTH-1:0] shift_r;
    logic                  chan_r;
    logic [DATA_WIDTH-1:0] left_hold_r;
    logic                  l_have_r;
    logic [12:0]           hold_cnt_r;

    logic                  lrck_edge_s;
    logic                  in_slot_s;
    logic                  short_set_s;
    logic [DATA_WIDTH-1:0] word_s;
    logic                  word_done_s;
    logic                  left_done_s;
    logic                  pair_done_s;
    logic                  load_s;
    logic                  overrun_set_s;
    logic [DATA_WIDTH-1:0] abs_l_s;
    logic [DATA_WIDTH-1:0] abs_r_s;
    logic [DATA_WIDTH-1:0] mag_s;

    // Two-stage synchronizers; BCLK gets a third stage for edge detection.
    always_ff @(posedge CLOCK or negedge DLY_RST) begin
        if (!DLY_RST) begin
            bclk_meta_r <= 1'b0;
            bclk_sync_r <= 1'b0;
            bclk_dly_r  <= 1'b0;
            lrck_meta_r <= 1'b0;
            lrck_sync_r <= 1'b0;
            dat_meta_r  <= 1'b0;
            dat_sync_r  <= 1'b0;
        end else begin
            bclk_meta_r <= BCLK;
            bclk_sync_r <= bclk_meta_r;
            bclk_dly_r  <= bclk_sync_r;
            lrck_meta_r <= ADCLRCK;
            lrck_sync_r <= lrck_meta_r;
            dat_meta_r  <= ADCDAT;
            dat_sync_r  <= dat_meta_r;
        end
    end

    assign bclk_rise_s = bclk_sync_r & ~bclk_dly_r;

    // Framing decode, pair completion and level magnitude.
    always_comb begin
        word_s    = {shift_r[DATA_WIDTH-2:0], dat_sync_r};
        // bitcnt of zero means no slot has been framed since reset, so the
        // stream is ignored until the first LRCK edge is seen.
        in_slot_s = (bitcnt_r != CNT_ZERO) && (bitcnt_r < CNT_FULL);
        // The first bit edge after reset only primes lrck_prev; releasing
        // reset mid-left-slot must not look like a frame edge.
        lrck_edge_s   = bclk_rise_s && prev_vld_r && (lrck_sync_r != lrck_prev_r);
        short_set_s   = lrck_edge_s && in_slot_s;
        word_done_s   = bclk_rise_s && !lrck_edge_s && (bitcnt_r == CNT_LAST);
        left_done_s   = word_done_s && chan_r;
        pair_done_s   = word_done_s && !chan_r && l_have_r;
        load_s        = pair_done_s && (!SAMPLE_VALID || SAMPLE_READY);
        overrun_set_s = pair_done_s && SAMPLE_VALID && !SAMPLE_READY;
        abs_l_s       = abs_sat(left_hold_r);
        abs_r_s       = abs_sat(word_s);
        if (abs_l_s >= abs_r_s) begin
            mag_s = abs_l_s;
        end else begin
            mag_s = abs_r_s;
        end
    end

    // Serial shift, bit counting and left-word holding, advanced per bit edge.
    always_ff @(posedge CLOCK or negedge DLY_RST) begin
        if (!DLY_RST) begin
            lrck_prev_r <= 1'b0;
            prev_vld_r  <= 1'b0;
            bitcnt_r    <= CNT_ZERO;
            shift_r     <= {DATA_WIDTH{1'b0}};
            chan_r      <= 1'b0;
            left_hold_r <= {DATA_WIDTH{1'b0}};
            l_have_r    <= 1'b0;
        end else if (bclk_rise_s) begin
            lrck_prev_r <= lrck_sync_r;
            prev_vld_r  <= 1'b1;
            if (lrck_edge_s) begin
                bitcnt_r <= CNT_ONE;
                shift_r  <= {{(DATA_WIDTH-1){1'b0}}, dat_sync_r};
                chan_r   <= lrck_sync_r;
            end else if (in_slot_s) begin
                bitcnt_r <= bitcnt_r + CNT_ONE;
                shift_r  <= word_s;
            end
            if (left_done_s) begin
                left_hold_r <= word_s;
                l_have_r    <= 1'b1;
            end else if (pair_done_s) begin
                l_have_r <= 1'b0;
            end
        end
    end

    // Output pair register, handshake and sticky error flags.
    always_ff @(posedge CLOCK or negedge DLY_RST) begin
        if (!DLY_RST) begin
            SAMPLE_L     <= {DATA_WIDTH{1'b0}};
            SAMPLE_R     <= {DATA_WIDTH{1'b0}};
            SAMPLE_VALID <= 1'b0;
            OVERRUN      <= 1'b0;
            SHORT_ERR    <= 1'b0;
        end else begin
            if (load_s) begin
                SAMPLE_L     <= left_hold_r;
                SAMPLE_R     <= word_s;
                SAMPLE_VALID <= 1'b1;
            end else if (SAMPLE_VALID && SAMPLE_READY) begin
                SAMPLE_VALID <= 1'b0;
            end
            OVERRUN   <= overrun_set_s | (OVERRUN & ~CLR_ERR);
            SHORT_ERR <= short_set_s | (SHORT_ERR & ~CLR_ERR);
        end
    end

    // Peak level and sound detect with a hold counted in pairs, dropped pairs included.
    always_ff @(posedge CLOCK or negedge DLY_RST) begin
        if (!DLY_RST) begin
            LEVEL      <= {DATA_WIDTH{1'b0}};
            SOUND_DET  <= 1'b0;
            hold_cnt_r <= 13'd0;
        end else if (pair_done_s) begin
            LEVEL <= mag_s;
            if (mag_s >= THRESHOLD) begin
                hold_cnt_r <= HOLD_LOAD;
                SOUND_DET  <= 1'b1;
            end else if (hold_cnt_r != 13'd0) begin
                hold_cnt_r <= hold_cnt_r - 13'd1;
                SOUND_DET  <= (hold_cnt_r != 13'd1);
            end else begin
                SOUND_DET <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_audio_adc_rx.sv
// Bench for audio_adc_rx: drives left-justified frames, keeps a frame-level
// reference model (words, handshake, sticky flags, level/hold) and compares
// the DUT against it at the end of every frame.
module tb_audio_adc_rx;

    localparam int HOLD = 5;
    localparam int THR  = 8000;

    logic        CLOCK = 1'b0;
    logic        DLY_RST = 1'b0;
    logic        BCLK = 1'b0;
    logic        ADCLRCK = 1'b0;
    logic        ADCDAT = 1'b0;
    logic        SAMPLE_READY = 1'b0;
    logic        CLR_ERR = 1'b0;
    logic [15:0] SAMPLE_L, SAMPLE_R, LEVEL;
    logic        SAMPLE_VALID, OVERRUN, SHORT_ERR, SOUND_DET;

    audio_adc_rx #(.DATA_WIDTH(16), .THRESHOLD(16'd8000), .HOLD_PAIRS(HOLD)) dut (
        .CLOCK(CLOCK), .DLY_RST(DLY_RST), .BCLK(BCLK), .ADCLRCK(ADCLRCK),
        .ADCDAT(ADCDAT), .SAMPLE_READY(SAMPLE_READY), .CLR_ERR(CLR_ERR),
        .SAMPLE_L(SAMPLE_L), .SAMPLE_R(SAMPLE_R), .SAMPLE_VALID(SAMPLE_VALID),
        .OVERRUN(OVERRUN), .SHORT_ERR(SHORT_ERR), .LEVEL(LEVEL), .SOUND_DET(SOUND_DET)
    );

    always #5 CLOCK = ~CLOCK;

    int n_checks = 0;
    int n_bad = 0;
    int cyc = 0;
    int bclk_half = 4;
    int rise_cyc = 0;
    int valid_rise_cyc = 0;
    logic valid_q = 1'b0;
    bit rdy_level = 1'b0;

    // reference model state
    bit          exp_valid, exp_ovr, exp_short, exp_sound;
    logic [15:0] exp_l, exp_r, exp_level;
    int          hold_left;
    bit          m_seen, m_last_lrck, m_prev_tracked, m_lhave;
    int          m_prev_bits;
    logic [15:0] m_left;
    logic [31:0] exp_acc[$];
    logic [31:0] got_acc[$];

    always @(posedge CLOCK) begin
        cyc = cyc + 1;
        if (SAMPLE_VALID && SAMPLE_READY) got_acc.push_back({SAMPLE_L, SAMPLE_R});
    end

    always @(negedge CLOCK) begin
        if (SAMPLE_VALID && !valid_q) valid_rise_cyc = cyc;
        valid_q = SAMPLE_VALID;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: run did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int mag(input logic [15:0] x);
        int v;
        v = $signed(x);
        if (v < 0) v = -v;
        if (v > 32767) v = 32767;
        return v;
    endfunction

    task automatic model_reset();
        exp_valid = 0; exp_ovr = 0; exp_short = 0; exp_sound = 0;
        exp_l = 16'h0; exp_r = 16'h0; exp_level = 16'h0; hold_left = 0;
        m_seen = 0; m_last_lrck = 0; m_prev_tracked = 0; m_lhave = 0;
        m_prev_bits = 0; m_left = 16'h0;
        exp_acc.delete();
        got_acc.delete();
    endtask

    task automatic set_ready(input bit v);
        rdy_level = v;
        SAMPLE_READY = v;
        if (v && exp_valid) begin
            exp_acc.push_back({exp_l, exp_r});
            exp_valid = 0;
        end
    endtask

    task automatic model_pair(input logic [15:0] l, input logic [15:0] r, input bit pulse);
        int lv;
        if (exp_valid && !(pulse || rdy_level)) begin
            exp_ovr = 1;
        end else begin
            if (exp_valid) exp_acc.push_back({exp_l, exp_r});
            exp_l = l; exp_r = r; exp_valid = 1;
            if (rdy_level) begin
                exp_acc.push_back({l, r});
                exp_valid = 0;
            end
        end
        lv = (mag(l) > mag(r)) ? mag(l) : mag(r);
        exp_level = 16'(lv);
        if (lv >= THR) begin
            hold_left = HOLD;
            exp_sound = 1;
        end else if (hold_left > 0) begin
            hold_left--;
            exp_sound = (hold_left > 0);
        end
    endtask

    task automatic send_bit(input logic l, input logic d, input bit pulse);
        BCLK = 1'b0; ADCLRCK = l; ADCDAT = d;
        repeat (bclk_half) @(negedge CLOCK);
        BCLK = 1'b1;
        rise_cyc = cyc;
        for (int k = 0; k < bclk_half; k++) begin
            if (pulse && k == 2) SAMPLE_READY = 1'b1;
            @(negedge CLOCK);
            if (pulse && k == 2) SAMPLE_READY = rdy_level;
        end
    endtask

    task automatic send_slot(input bit chan, input int nbits, input logic [15:0] word, input bit pulse);
        bit   tracked;
        logic d;
        tracked = m_seen && (chan != m_last_lrck);
        if (tracked && m_prev_tracked && m_prev_bits < 16) exp_short = 1;
        for (int i = 0; i < nbits; i++) begin
            d = (i < 16) ? word[15-i] : 1'($urandom_range(1, 0));
            send_bit(chan, d, pulse && (i == 15));
        end
        m_seen = 1; m_last_lrck = chan; m_prev_tracked = tracked; m_prev_bits = nbits;
        if (tracked && nbits >= 16) begin
            if (chan) begin
                m_left = word;
                m_lhave = 1;
            end else if (m_lhave) begin
                m_lhave = 0;
                model_pair(m_left, word, pulse);
            end
        end
    endtask

    task automatic check_state(input string tag);
        repeat (2) @(negedge CLOCK);
        check_val({tag, ":valid"}, 32'(SAMPLE_VALID), 32'(exp_valid));
        check_val({tag, ":L"}, 32'(SAMPLE_L), 32'(exp_l));
        check_val({tag, ":R"}, 32'(SAMPLE_R), 32'(exp_r));
        check_val({tag, ":ovr"}, 32'(OVERRUN), 32'(exp_ovr));
        check_val({tag, ":short"}, 32'(SHORT_ERR), 32'(exp_short));
        check_val({tag, ":level"}, 32'(LEVEL), 32'(exp_level));
        check_val({tag, ":sound"}, 32'(SOUND_DET), 32'(exp_sound));
        check_val({tag, ":acc_n"}, got_acc.size(), exp_acc.size());
        for (int i = 0; i < exp_acc.size() && i < got_acc.size(); i++)
            check_val({tag, ":acc"}, got_acc[i], exp_acc[i]);
        got_acc.delete();
        exp_acc.delete();
    endtask

    task automatic send_frame(input string tag, input logic [15:0] l, input logic [15:0] r,
                              input int nl, input int nr, input bit pulse);
        send_slot(1'b1, nl, l, 1'b0);
        send_slot(1'b0, nr, r, pulse);
        check_state(tag);
    endtask

    task automatic clear_err();
        CLR_ERR = 1'b1;
        @(negedge CLOCK);
        CLR_ERR = 1'b0;
        exp_ovr = 0; exp_short = 0;
        @(negedge CLOCK);
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, ":valid"}, 32'(SAMPLE_VALID), 32'd0);
        check_val({tag, ":L"}, 32'(SAMPLE_L), 32'd0);
        check_val({tag, ":R"}, 32'(SAMPLE_R), 32'd0);
        check_val({tag, ":flags"}, 32'({OVERRUN, SHORT_ERR, SOUND_DET}), 32'd0);
        check_val({tag, ":level"}, 32'(LEVEL), 32'd0);
    endtask

    initial begin
        logic [15:0] wl, wr;
        model_reset();
        repeat (4) @(negedge CLOCK);
        check_zero("reset");
        DLY_RST = 1'b1;                       // released during a right slot
        send_slot(1'b0, 5, 16'hFFFF, 1'b0);   // tail of a right slot: ignored

        // nominal capture at CLOCK/32
        bclk_half = 16;
        send_frame("nominal", 16'h1234, 16'hFEDC, 16, 16, 1'b0);
        check_val("nominal:latency", 32'(valid_rise_cyc - rise_cyc), 32'd3);
        bclk_half = 4;

        // backpressure: pair held, overrun, then a lossless accept-cycle load
        send_frame("bp1", 16'h1111, 16'h2222, 16, 16, 1'b0);
        send_frame("bp2", 16'h3333, 16'h4444, 16, 16, 1'b0);
        clear_err();
        check_val("clr:ovr", 32'(OVERRUN), 32'd0);
        send_frame("bp_accept", 16'h5555, 16'h6666, 16, 16, 1'b1);

        // short left slot, then a normal frame
        set_ready(1'b1);
        send_frame("short", 16'h0F0F, 16'h0A0A, 10, 16, 1'b0);
        send_frame("after_short", 16'h0102, 16'h0304, 16, 16, 1'b0);
        clear_err();

        // extra bits per slot are ignored
        set_ready(1'b0);
        send_frame("extra", 16'hA5A5, 16'hA5A5, 24, 24, 1'b0);

        // level and hold
        set_ready(1'b1);
        send_frame("lvl_8000", 16'h8000, 16'h0000, 16, 16, 1'b0);
        for (int i = 0; i < HOLD; i++) send_frame("hold", 16'h0000, 16'h0000, 16, 16, 1'b0);
        set_ready(1'b0);
        send_frame("lvl_thr", 16'hE0C0, 16'h0000, 16, 16, 1'b0);
        send_frame("lvl_below", 16'hE0C1, 16'h0010, 16, 16, 1'b0);

        // reset in the middle of a left slot
        send_slot(1'b1, 7, 16'h7F00, 1'b0);
        DLY_RST = 1'b0;
        BCLK = 1'b0;
        #1;
        check_zero("rst_async");
        model_reset();
        repeat (4) @(negedge CLOCK);
        DLY_RST = 1'b1;
        send_slot(1'b0, 9, 16'hFFFF, 1'b0);
        send_slot(1'b1, 16, 16'h2468, 1'b0);
        check_state("rst_left_only");
        send_slot(1'b0, 16, 16'h1357, 1'b0);
        check_state("rst_recover");

        // randomized frames
        for (int n = 0; n < 30; n++) begin
            set_ready(1'($urandom_range(1, 0)));
            wl = 16'($urandom);
            wr = 16'($urandom);
            if ($urandom_range(1, 0) == 1) wl = {{4{wl[15]}}, wl[11:0]};
            if ($urandom_range(1, 0) == 1) wr = {{4{wr[15]}}, wr[11:0]};
            send_frame("rand", wl, wr, 16 + $urandom_range(3, 0), 16 + $urandom_range(3, 0), 1'b0);
            if ($urandom_range(3, 0) == 0) clear_err();
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
